alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Operand-issue stage directly upstream of the ALU in the pipelined computer.
//  Captures decoded register operands and selects the ALU A/B inputs: shift amount or rs, immediate or rt.
//  Applies write-back forwarding and holds up to two ops in a skid buffer, so ALU back-pressure never drops an op.
//  All ALU-facing outputs are registered; there is no combinational in->out path.
// PARAMETERS
//  DW      32  datapath width (operands, immediate, write-back data)
//  RW      5   register-number width
//  ALUC_W  4   ALU control code width (passed through unmodified)
// PORTS
//  clock       in   1       rising-edge clock
//  resetn      in   1       asynchronous active-low reset
//  in_valid    in   1       upstream op valid
//  in_ready    out  1       stage can accept (= skid slot empty)
//  in_qa/in_qb in   DW      register-file reads of rs/rt
//  in_rs/in_rt in   RW      source register numbers
//  in_imm      in   DW      extended immediate
//  in_sa       in   5       shift amount
//  in_aluc     in   ALUC_W  ALU control code
//  in_shift    in   1       1: A = {zeros,sa}; 0: A = rs value
//  in_aluimm   in   1       1: B = imm; 0: B = rt value
//  in_wreg     in   1       op writes a register
//  in_rn       in   RW      destination register
//  wb_we       in   1       write-back strobe
//  wb_rn       in   RW      write-back register number
//  wb_d        in   DW      write-back data
//  flush       in   1       synchronous kill of all held/incoming ops
//  out_valid   out  1       op valid toward the ALU
//  out_ready   in   1       ALU side accepts
//  out_a/out_b out  DW      ALU operands
//  out_aluc/out_wreg/out_rn out  ALUC_W/1/RW  passed-through controls
// BEHAVIOUR
//  Reset (resetn low, async): count=EMPTY; all out_* = 0; out_valid = 0; in_ready = 1.
//  Accept = in_valid & in_ready; pop = out_valid & out_ready. Both are sampled at the rising edge.
//  Two entries exist: main drives out_*, skid is internal. out_valid = main valid; in_ready = ~skid valid.
//  FSM on count:
//   EMPTY: accept -> ONE (op into main).
//   ONE:   accept & ~pop -> TWO (op into skid); accept & pop -> ONE (op replaces main); pop only -> EMPTY.
//   TWO:   in_ready = 0; pop -> ONE (skid moves to main); otherwise hold.
//  Latency: an op accepted at edge k is visible on out_* after edge k; 1 cycle minimum.
//  Order is strict FIFO. No op is lost or duplicated.
//  Operand select at capture: A = in_shift ? {(DW-5)'b0,in_sa} : fwd(in_qa,in_rs);
//   B = in_aluimm ? in_imm : fwd(in_qb,in_rt).
//  fwd(q,r) = (wb_we & wb_rn==r & r!=0) ? wb_d : q.
//  Each entry stores rs/rt plus use_a = ~shift and use_b = ~aluimm.
//  Held-entry forwarding: on every edge where wb_we & wb_rn!=0:
//   every held entry (main, skid, or skid moving to main) with use_a & rs==wb_rn takes A <= wb_d;
//   likewise B when use_b & rt==wb_rn. Register 0 is never forwarded.
//  Flush (sync, highest priority after reset): next state EMPTY, out_valid=0.
//   An op offered the same cycle is dropped; pop that cycle is still counted by the ALU side.
//  Data fields of invalid entries are don't-care except at reset. Width is exact; there is no sign handling here.
// TESTING
//  1 Reset mid-op: fill TWO, pull resetn low -> out_valid=0 and in_ready=1 at once.
//  2 Streaming: out_ready=1, 8 back-to-back ops -> out_valid continuous, 1-cycle latency, order preserved, never TWO.
//  3 Back-pressure: out_ready=0, 3 ops offered -> in_ready=0 after 2nd accept, 3rd held upstream;
//    then out_ready=1 -> ops 1,2,3 in order.
//  4 Forwarding: op rs=5 in_qa=0x11, wb_we rn=5 d=0xAB same cycle -> out_a=0xAB;
//    while held in skid, wb rn=6 d=0x77 with rt=6 -> out_b=0x77 on issue; wb rn=0 -> no change.
//  5 Select: in_shift=1 sa=3 -> out_a=3 ignoring wb to rs; in_aluimm=1 imm=0xFFFF8000 -> out_b=0xFFFF8000.
//  6 Flush in TWO with in_valid high -> next cycle EMPTY, out_valid=0, in_ready=1, incoming op absent.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the ALU: operand select, write-back forwarding,
// and a two-entry skid buffer so ALU back-pressure never drops an op.
module alu_issue_stage #(
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int ALUC_W = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_qa,
   input  logic [DW-1:0]     in_qb,
   input  logic [RW-1:0]     in_rs,
   input  logic [RW-1:0]     in_rt,
   input  logic [DW-1:0]     in_imm,
   input  logic [4:0]        in_sa,
   input  logic [ALUC_W-1:0] in_aluc,
   input  logic              in_shift,
   input  logic              in_aluimm,
   input  logic              in_wreg,
   input  logic [RW-1:0]     in_rn,
   input  logic              wb_we,
   input  logic [RW-1:0]     wb_rn,
   input  logic [DW-1:0]     wb_d,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_a,
   output logic [DW-1:0]     out_b,
   output logic [ALUC_W-1:0] out_aluc,
   output logic              out_wreg,
   output logic [RW-1:0]     out_rn
);

   typedef struct packed {
      logic [DW-1:0]     a;
      logic [DW-1:0]     b;
      logic [RW-1:0]     rs;
      logic [RW-1:0]     rt;
      logic              use_a;
      logic              use_b;
      logic [ALUC_W-1:0] aluc;
      logic              wreg;
      logic [RW-1:0]     rn;
   } ent_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } state_e;

   state_e state_q, state_d;
   ent_t   main_q, main_d;
   ent_t   skid_q, skid_d;
   ent_t   new_e;
   ent_t   main_f;
   ent_t   skid_f;
   logic   wb_hit;
   logic   acc;
   logic   pop;

   assign wb_hit = wb_we && (wb_rn != '0);

   function automatic logic [DW-1:0] fwd_val(
      input logic [DW-1:0] q,
      input logic [RW-1:0] r,
      input logic          hit,
      input logic [RW-1:0] wrn,
      input logic [DW-1:0] wd
   );
      return (hit && wrn == r) ? wd : q;
   endfunction

   // Held entries keep tracking write-backs until they leave for the ALU
   function automatic ent_t fwd_ent(
      input ent_t          e,
      input logic          hit,
      input logic [RW-1:0] wrn,
      input logic [DW-1:0] wd
   );
      ent_t r;
      r = e;
      if (hit && e.use_a && e.rs == wrn) r.a = wd;
      if (hit && e.use_b && e.rt == wrn) r.b = wd;
      return r;
   endfunction

   always_comb begin
      new_e       = '0;
      new_e.a     = in_shift ? {{(DW-5){1'b0}}, in_sa}
                             : fwd_val(in_qa, in_rs, wb_hit, wb_rn, wb_d);
      new_e.b     = in_aluimm ? in_imm
                              : fwd_val(in_qb, in_rt, wb_hit, wb_rn, wb_d);
      new_e.rs    = in_rs;
      new_e.rt    = in_rt;
      new_e.use_a = ~in_shift;
      new_e.use_b = ~in_aluimm;
      new_e.aluc  = in_aluc;
      new_e.wreg  = in_wreg;
      new_e.rn    = in_rn;
   end

   assign main_f    = fwd_ent(main_q, wb_hit, wb_rn, wb_d);
   assign skid_f    = fwd_ent(skid_q, wb_hit, wb_rn, wb_d);

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != TWO);
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_f;
      skid_d  = skid_f;
      unique case (state_q)
         EMPTY: begin
            if (acc) begin
               main_d  = new_e;
               state_d = ONE;
            end
         end
         ONE: begin
            if (acc && !pop) begin
               skid_d  = new_e;
               state_d = TWO;
            end else if (acc) begin
               main_d = new_e;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               main_d  = skid_f;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign out_a    = main_q.a;
   assign out_b    = main_q.b;
   assign out_aluc = main_q.aluc;
   assign out_wreg = main_q.wreg;
   assign out_rn   = main_q.rn;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops with hand-computed
// operands, checked in order by an independent output monitor.
module tb_alu_issue_stage;

   logic        clock;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_qa;
   logic [31:0] in_qb;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [31:0] in_imm;
   logic [4:0]  in_sa;
   logic [3:0]  in_aluc;
   logic        in_shift;
   logic        in_aluimm;
   logic        in_wreg;
   logic [4:0]  in_rn;
   logic        wb_we;
   logic [4:0]  wb_rn;
   logic [31:0] wb_d;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [3:0]  out_aluc;
   logic        out_wreg;
   logic [4:0]  out_rn;

   typedef logic [73:0] exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   alu_issue_stage #(.DW(32), .RW(5), .ALUC_W(4)) dut (
      .clock(clock), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_qa(in_qa), .in_qb(in_qb),
      .in_rs(in_rs), .in_rt(in_rt),
      .in_imm(in_imm), .in_sa(in_sa),
      .in_aluc(in_aluc), .in_shift(in_shift),
      .in_aluimm(in_aluimm), .in_wreg(in_wreg),
      .in_rn(in_rn),
      .wb_we(wb_we), .wb_rn(wb_rn), .wb_d(wb_d),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b),
      .out_aluc(out_aluc), .out_wreg(out_wreg),
      .out_rn(out_rn)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input exp_t got, input exp_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Handshake completes at the next rising edge; outputs are stable here
   always @(negedge clock) begin
      if (resetn && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_op got=%h expected=none",
                     {out_a, out_b, out_aluc, out_wreg, out_rn});
         end else begin
            chk("issue", {out_a, out_b, out_aluc, out_wreg, out_rn},
                q.pop_front());
         end
      end
   end

   task automatic set_op(
      input logic [31:0] qa, input logic [4:0] rs,
      input logic [31:0] qb, input logic [4:0] rt,
      input logic [31:0] imm, input logic [4:0] sa,
      input logic sh, input logic ai,
      input logic [3:0] aluc, input logic wr, input logic [4:0] rn
   );
      in_qa = qa; in_rs = rs; in_qb = qb; in_rt = rt;
      in_imm = imm; in_sa = sa; in_shift = sh; in_aluimm = ai;
      in_aluc = aluc; in_wreg = wr; in_rn = rn;
   endtask

   task automatic send(
      input logic [31:0] qa, input logic [4:0] rs,
      input logic [31:0] qb, input logic [4:0] rt,
      input logic [31:0] imm, input logic [4:0] sa,
      input logic sh, input logic ai,
      input logic [3:0] aluc, input logic wr, input logic [4:0] rn,
      input logic wwe, input logic [4:0] wrn, input logic [31:0] wd,
      input logic [31:0] ea, input logic [31:0] eb,
      output int waited
   );
      bit ok;
      ok = 0;
      waited = 0;
      set_op(qa, rs, qb, rt, imm, sa, sh, ai, aluc, wr, rn);
      wb_we = wwe; wb_rn = wrn; wb_d = wd;
      in_valid = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clock);
         if (in_ready) begin
            q.push_back({ea, eb, aluc, wr, rn});
            ok = 1;
         end else begin
            waited++;
         end
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      wb_we = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout got=no_accept expected=accept");
      end
   endtask

   task automatic drain();
      bit done;
      done = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 30 && !done; c++) begin
         @(posedge clock);
         #1;
         if (q.size() == 0) done = 1;
      end
      chk("drain_done", exp_t'(done), exp_t'(1));
      chk("drain_empty", exp_t'(out_valid), exp_t'(0));
   endtask

   int w;

   initial begin
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      wb_we = 1'b0; wb_rn = '0; wb_d = '0;
      set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out_valid", exp_t'(out_valid), exp_t'(0));
      chk("rst_in_ready", exp_t'(in_ready), exp_t'(1));
      chk("rst_out_data", {out_a, out_b, out_aluc, out_wreg, out_rn}, '0);
      resetn = 1'b1;
      @(posedge clock);
      #1;

      // Streaming: back-to-back with the ALU always ready
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(32'h100 + i, 5'(i + 1), 32'h200 + i, 5'(i + 9), 0, 0, 0, 0,
              4'(i), i[0], 5'(i + 16), 0, 0, 0,
              32'h100 + i, 32'h200 + i, w);
         chk("stream_nowait", exp_t'(w), exp_t'(0));
         chk("stream_valid", exp_t'(out_valid), exp_t'(1));
      end
      drain();

      // Back-pressure: third op waits upstream
      out_ready = 1'b0;
      send(32'h31, 1, 32'h32, 2, 0, 0, 0, 0, 4'h1, 1, 5'd3, 0, 0, 0,
           32'h31, 32'h32, w);
      send(32'h41, 1, 32'h42, 2, 0, 0, 0, 0, 4'h2, 0, 5'd4, 0, 0, 0,
           32'h41, 32'h42, w);
      chk("bp_full", exp_t'(in_ready), exp_t'(0));
      set_op(32'h51, 1, 32'h52, 2, 0, 0, 0, 0, 4'h3, 1, 5'd5);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk("bp_hold", exp_t'(in_ready), exp_t'(0));
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send(32'h51, 1, 32'h52, 2, 0, 0, 0, 0, 4'h3, 1, 5'd5, 0, 0, 0,
           32'h51, 32'h52, w);
      drain();

      // Forwarding at capture and while held in skid
      out_ready = 1'b0;
      send(32'h11, 5, 32'h22, 7, 0, 0, 0, 0, 4'h4, 1, 5'd8,
           1, 5'd5, 32'hAB, 32'hAB, 32'h22, w);
      send(32'h01, 0, 32'h66, 6, 0, 0, 0, 0, 4'h5, 1, 5'd9,
           0, 0, 0, 32'h01, 32'h77, w);
      wb_we = 1'b1; wb_rn = 5'd6; wb_d = 32'h77;
      @(posedge clock);
      #1;
      wb_rn = 5'd0; wb_d = 32'hDEAD;
      @(posedge clock);
      #1;
      wb_we = 1'b0;
      drain();

      // Select: shift amount and immediate ignore forwarding
      out_ready = 1'b0;
      send(32'h55, 9, 32'h33, 9, 32'hFFFF8000, 5'd3, 1, 1, 4'h6, 1, 5'd10,
           1, 5'd9, 32'h99, 32'h3, 32'hFFFF8000, w);
      send(32'hA0, 10, 32'hB0, 0, 0, 0, 0, 0, 4'h7, 0, 5'd11,
           0, 0, 0, 32'h1010, 32'hB0, w);
      wb_we = 1'b1; wb_rn = 5'd9; wb_d = 32'h99;
      @(posedge clock);
      #1;
      // skid moves to main on this edge while rs=10 is written back
      wb_rn = 5'd10; wb_d = 32'h1010; out_ready = 1'b1;
      @(posedge clock);
      #1;
      wb_we = 1'b0;
      drain();

      // Flush while full with an op offered
      out_ready = 1'b0;
      send(32'hE1, 1, 32'hE2, 2, 0, 0, 0, 0, 4'h8, 1, 5'd12, 0, 0, 0,
           32'hE1, 32'hE2, w);
      send(32'hF1, 1, 32'hF2, 2, 0, 0, 0, 0, 4'h9, 1, 5'd13, 0, 0, 0,
           32'hF1, 32'hF2, w);
      set_op(32'hC1, 1, 32'hC2, 2, 0, 0, 0, 0, 4'hA, 1, 5'd14);
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      q.delete();
      chk("flush_valid", exp_t'(out_valid), exp_t'(0));
      chk("flush_ready", exp_t'(in_ready), exp_t'(1));
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         chk("flush_absent", exp_t'(out_valid), exp_t'(0));
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send(32'hD1, 3, 32'hD2, 4, 0, 0, 0, 0, 4'hB, 0, 5'd15, 0, 0, 0,
           32'hD1, 32'hD2, w);
      drain();

      // Async reset while full
      out_ready = 1'b0;
      send(32'h61, 1, 32'h62, 2, 0, 0, 0, 0, 4'hC, 1, 5'd17, 0, 0, 0,
           32'h61, 32'h62, w);
      send(32'h71, 1, 32'h72, 2, 0, 0, 0, 0, 4'hD, 1, 5'd18, 0, 0, 0,
           32'h71, 32'h72, w);
      @(negedge clock);
      chk("pre_rst_full", exp_t'(in_ready), exp_t'(0));
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", exp_t'(out_valid), exp_t'(0));
      chk("mid_rst_ready", exp_t'(in_ready), exp_t'(1));
      chk("mid_rst_data", {out_a, out_b, out_aluc, out_wreg, out_rn}, '0);
      q.delete();
      @(posedge clock);
      #1;
      resetn = 1'b1;
      @(posedge clock);
      #1;
      chk("post_rst_valid", exp_t'(out_valid), exp_t'(0));
      chk("sb_empty", exp_t'(q.size()), exp_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
